pe_tile_feeder: RTL and testbench
=================================

# pe_tile_feeder

Operand-side driver for a registered processing-element wrapper: accepts a tile command plus a stream of operands and produces the cycle-accurate `io_in_*` input bundle (a, b, d, valid, control_shift, control_propagate) that the PE consumes. It sits between the scratchpad read path and the first PE of a row. It sequences an optional d-preload phase, a compute phase and a pipeline-drain phase, then reports completion. It also owns the per-tile propagate (double-buffer select) bit.

## Interface
- `A_W`, 8, width of operand a
- `B_W`, 19, width of operand b
- `D_W`, 19, width of preload operand d
- `SHIFT_W`, 6, width of control shift
- `DIM`, 16, maximum beats per phase
- `DRAIN_CYCLES`, 4, idle cycles after the last compute beat (covers PE wrapper input register + PE + output register)
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  tile command offered
- `cmd_ready`  out  1  command accepted when both high
- `cmd_rows`  in  8  beats per phase
- `cmd_shift`  in  SHIFT_W  output shift for this tile
- `cmd_preload`  in  1  run the d-preload phase before compute
- `op_valid`  in  1  operand beat offered
- `op_ready`  out  1  operand beat accepted when both high
- `op_a`  in  A_W; `op_b`  in  B_W; `op_d`  in  D_W  operand data
- `io_in_a1`  out  A_W; `io_in_b1`  out  B_W; `io_in_d1`  out  D_W  PE operands
- `io_in_valid1`  out  1  PE beat valid
- `io_in_control_shift1`  out  SHIFT_W  PE shift
- `io_in_control_propagate1`  out  1  PE propagate select
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, PRELOAD, COMPUTE, DRAIN, DONE.
- IDLE: `cmd_ready`=1. On accept, latch rows_eff = min(cmd_rows, DIM) and shift. If `cmd_preload`=1, toggle the propagate register. Next state is PRELOAD if preload=1 and rows_eff>0; COMPUTE if preload=0 and rows_eff>0; DONE if rows_eff=0 (propagate still toggles).
- PRELOAD: `op_ready`=1. Each accepted beat loads `io_in_d1`=op_d, `io_in_a1`=0, `io_in_b1`=0, `io_in_valid1`=1. After rows_eff beats go to COMPUTE.
- COMPUTE: `op_ready`=1. Each accepted beat loads `io_in_a1`=op_a, `io_in_b1`=op_b, `io_in_d1`=0, `io_in_valid1`=1. After rows_eff beats go to DRAIN.
- Operand beats with no valid operand produce a bubble: `io_in_valid1`=0 and the data outputs hold their previous values. The beat counter advances only on accepted beats.
- DRAIN: `op_ready`=0 and `io_in_valid1`=0 for exactly DRAIN_CYCLES cycles, then go to DONE.
- DONE: `done`=1 for one cycle, `cmd_ready`=0, then return to IDLE.
- `io_in_control_shift1` and `io_in_control_propagate1` are registered from the latched command. They are stable from the cycle after command accept until the next accept.
- `op_ready` is 0 in IDLE, DRAIN and DONE. `cmd_ready` is 0 outside IDLE.
- Beat counter width is clog2(DIM+1). Comparisons use rows_eff, so there is no wrap-around.

## Timing
- Every `io_in_*1` output is a flop. A beat accepted at edge n appears on the outputs after edge n, and is held for exactly one cycle with valid=1.
- Command accept at edge n: state, shift and propagate are updated after edge n. The first operand can be accepted at edge n+1.
- Minimum tile with rows=R, preload=1 and no bubbles: 1 (cmd) + 2R + DRAIN_CYCLES + 1 (DONE) cycles from cmd accept to `done` high.
- Reset (RST=0, asynchronous) forces:
  - State to IDLE.
  - All `io_in_*1` outputs to 0, including propagate.
  - `busy`, `done` and `op_ready` to 0.
  - `cmd_ready` to 1 once RST is released.
- Reset mid-tile abandons the tile with no `done` pulse.
- Deassertion is synchronized by the system reset tree. The block assumes a clean release.
- A `cmd_valid` held high in DONE is accepted in the following IDLE cycle. There is no IDLE-skip.

## Test plan
- Reset: drive RST=0 mid-COMPUTE -> all outputs 0 immediately; after release `cmd_ready`=1, `busy`=0, and propagate is 0.
- Preload tile, rows=3, shift=5, preload=1, operands d={7,8,9} then (a,b)={(1,2),(3,4),(5,6)} back-to-back:
  - `io_in_valid1` is high for 6 consecutive cycles starting one cycle after the first operand accept.
  - d sequence is 7,8,9, with a=b=0 on those beats.
  - Compute beats carry a/b 1/2, 3/4, 5/6 with d=0.
  - shift=5 and propagate=1 hold throughout.
  - Then 4 invalid cycles, then `done` high for one cycle.
- Bubbles: rows=2, preload=0, op_valid pattern 1,0,0,1 -> `io_in_valid1` pattern 1,0,0,1 lagging by one cycle; data held during bubbles; propagate unchanged from the previous tile.
- Clamp and zero: rows=40 with DIM=16 -> exactly 16 compute beats accepted, and `op_ready` drops after the 16th. rows=0 with preload=1 -> no valid beats, `done` two cycles after accept, and propagate toggles.
- Back-to-back commands: `cmd_valid` held high across two tiles -> `cmd_ready` is low in DONE; the second tile is accepted in the IDLE cycle after `done`; propagate alternates 1,0 for two preload tiles.

Source files
------------

// File: rtl/pe_tile_feeder_if.sv
// rtl/pe_tile_feeder_if.sv - tile command and operand handshake channels for pe_tile_feeder
//
// Signals:
//   cmd_valid / cmd_ready          tile command handshake
//   cmd_rows[7:0]                  requested beats per phase
//   cmd_shift[SHIFT_W-1:0]         output shift for the tile
//   cmd_preload                    run the d-preload phase before compute
//   op_valid / op_ready            operand beat handshake
//   op_a / op_b / op_d             operand data
// Modports:
//   master - command/operand producer (scratchpad read side)
//   slave  - pe_tile_feeder
interface pe_tile_feeder_if #(
  parameter int A_W     = 8,
  parameter int B_W     = 19,
  parameter int D_W     = 19,
  parameter int SHIFT_W = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [7:0]         cmd_rows;
  logic [SHIFT_W-1:0] cmd_shift;
  logic               cmd_preload;

  logic               op_valid;
  logic               op_ready;
  logic [A_W-1:0]     op_a;
  logic [B_W-1:0]     op_b;
  logic [D_W-1:0]     op_d;

  modport master (
    output cmd_valid, cmd_rows, cmd_shift, cmd_preload,
    input  cmd_ready,
    output op_valid, op_a, op_b, op_d,
    input  op_ready
  );

  modport slave (
    input  cmd_valid, cmd_rows, cmd_shift, cmd_preload,
    output cmd_ready,
    input  op_valid, op_a, op_b, op_d,
    output op_ready
  );
endinterface

// File: rtl/pe_tile_feeder.sv
// rtl/pe_tile_feeder.sv - sequences preload/compute/drain beats into the registered PE input bundle
//
// Ports:
//   i_clk                          clock, rising edge
//   i_rst_n                        asynchronous active-low reset
//   s_if                           command + operand channels (slave modport)
//   o_io_in_a1/b1/d1               PE operands (registered)
//   o_io_in_valid1                 PE beat valid (registered)
//   o_io_in_control_shift1         PE shift (registered from latched command)
//   o_io_in_control_propagate1     PE double-buffer select (toggles on preload tiles)
//   o_busy                         feeder not idle
//   o_done                         one-cycle tile completion pulse
module pe_tile_feeder #(
  parameter int A_W          = 8,
  parameter int B_W          = 19,
  parameter int D_W          = 19,
  parameter int SHIFT_W      = 6,
  parameter int DIM          = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  pe_tile_feeder_if.slave    s_if,
  output logic [A_W-1:0]     o_io_in_a1,
  output logic [B_W-1:0]     o_io_in_b1,
  output logic [D_W-1:0]     o_io_in_d1,
  output logic               o_io_in_valid1,
  output logic [SHIFT_W-1:0] o_io_in_control_shift1,
  output logic               o_io_in_control_propagate1,
  output logic               o_busy,
  output logic               o_done
);

  localparam int CNT_W = $clog2(DIM + 1);
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [CNT_W-1:0]   r_rows;
  logic [CNT_W-1:0]   r_cnt;
  logic [DRN_W-1:0]   r_drain;
  logic [A_W-1:0]     r_a;
  logic [B_W-1:0]     r_b;
  logic [D_W-1:0]     r_d;
  logic               r_valid;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_prop;

  logic               w_cmd_ready;
  logic               w_op_ready;
  logic               w_busy;
  logic               w_done;
  logic               w_cmd_fire;
  logic               w_op_fire;
  logic               w_last_beat;
  logic               w_drain_last;
  logic [CNT_W-1:0]   w_rows_eff;

  // Requests beyond the array dimension are clamped, so the counter never wraps.
  assign w_rows_eff   = (32'(s_if.cmd_rows) > DIM) ? CNT_W'(DIM) : CNT_W'(s_if.cmd_rows);
  assign w_cmd_fire   = s_if.cmd_valid && w_cmd_ready;
  assign w_op_fire    = s_if.op_valid && w_op_ready;
  // Only evaluated in PRELOAD/COMPUTE, where r_rows is at least 1.
  assign w_last_beat  = (r_cnt == r_rows - CNT_W'(1));
  assign w_drain_last = (r_drain == DRN_W'(DRAIN_CYCLES - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          if (w_rows_eff == '0)        w_next_state = S_DONE;
          else if (s_if.cmd_preload)   w_next_state = S_PRELOAD;
          else                         w_next_state = S_COMPUTE;
        end
      end
      S_PRELOAD: if (w_op_fire && w_last_beat) w_next_state = S_COMPUTE;
      S_COMPUTE: if (w_op_fire && w_last_beat) w_next_state = S_DRAIN;
      S_DRAIN:   if (w_drain_last)             w_next_state = S_DONE;
      S_DONE:                                  w_next_state = S_IDLE;
      default:                                 w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_cmd_ready = 1'b0;
    w_op_ready  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
      end
      S_PRELOAD, S_COMPUTE: w_op_ready = 1'b1;
      S_DONE:               w_done     = 1'b1;
      default: ;
    endcase
  end

  // Datapath: command latch, beat counter, drain counter and the PE input flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rows  <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_valid <= 1'b0;
      r_shift <= '0;
      r_prop  <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_cmd_fire) begin
        r_rows  <= w_rows_eff;
        r_cnt   <= '0;
        r_shift <= s_if.cmd_shift;
        // Preload fills the shadow buffer, so the PE must swap to it for this tile.
        r_prop  <= r_prop ^ s_if.cmd_preload;
      end

      // Bubbles leave a/b/d untouched; only valid drops.
      if (w_op_fire) begin
        r_valid <= 1'b1;
        r_cnt   <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
        if (r_state == S_PRELOAD) begin
          r_a <= '0;
          r_b <= '0;
          r_d <= s_if.op_d;
        end else begin
          r_a <= s_if.op_a;
          r_b <= s_if.op_b;
          r_d <= '0;
        end
      end

      if (r_state == S_DRAIN) begin
        r_drain <= w_drain_last ? '0 : r_drain + DRN_W'(1);
      end
    end
  end

  assign s_if.cmd_ready             = w_cmd_ready;
  assign s_if.op_ready              = w_op_ready;
  assign o_busy                     = w_busy;
  assign o_done                     = w_done;
  assign o_io_in_a1                 = r_a;
  assign o_io_in_b1                 = r_b;
  assign o_io_in_d1                 = r_d;
  assign o_io_in_valid1             = r_valid;
  assign o_io_in_control_shift1     = r_shift;
  assign o_io_in_control_propagate1 = r_prop;

endmodule

// File: tb/tb_pe_tile_feeder.sv
// tb/tb_pe_tile_feeder.sv - self-checking bench for pe_tile_feeder against a beat-level reference model
module tb_pe_tile_feeder;
  localparam int A_W          = 8;
  localparam int B_W          = 19;
  localparam int D_W          = 19;
  localparam int SHIFT_W      = 6;
  localparam int DIM          = 16;
  localparam int DRAIN_CYCLES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_tile_feeder_if #(.A_W(A_W), .B_W(B_W), .D_W(D_W), .SHIFT_W(SHIFT_W)) bus ();

  logic [A_W-1:0]     o_a;
  logic [B_W-1:0]     o_b;
  logic [D_W-1:0]     o_d;
  logic               o_valid;
  logic [SHIFT_W-1:0] o_shift;
  logic               o_prop;
  logic               o_busy;
  logic               o_done;

  pe_tile_feeder #(
    .A_W(A_W), .B_W(B_W), .D_W(D_W), .SHIFT_W(SHIFT_W),
    .DIM(DIM), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .i_clk                      (clk),
    .i_rst_n                    (rst_n),
    .s_if                       (bus),
    .o_io_in_a1                 (o_a),
    .o_io_in_b1                 (o_b),
    .o_io_in_d1                 (o_d),
    .o_io_in_valid1             (o_valid),
    .o_io_in_control_shift1     (o_shift),
    .o_io_in_control_propagate1 (o_prop),
    .o_busy                     (o_busy),
    .o_done                     (o_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: what the PE input bundle should be holding.
  logic [A_W-1:0]     m_a;
  logic [B_W-1:0]     m_b;
  logic [D_W-1:0]     m_d;
  logic [SHIFT_W-1:0] m_shift;
  logic               m_prop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_d = '0; m_shift = '0; m_prop = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},     32'(o_a), 0);
    chk({tag, "_b"},     32'(o_b), 0);
    chk({tag, "_d"},     32'(o_d), 0);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_shift"}, 32'(o_shift), 0);
    chk({tag, "_prop"},  32'(o_prop), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
    chk({tag, "_done"},  32'(o_done), 0);
    chk({tag, "_opr"},   32'(bus.op_ready), 0);
  endtask

  // Runs one tile from the IDLE cycle through the DONE cycle, returning in the
  // following IDLE cycle (time = posedge + 1). The model is expressed in beats:
  // the tile needs 'total' accepted operands, each appears one cycle later,
  // and done follows the last accepted beat by DRAIN_CYCLES + 1 cycles.
  task automatic run_tile(input int rows, input int shift, input bit pre, input bit hold,
                          input bit rnd, input bit fixed, input int plen,
                          input logic [15:0] pat, input int abort_at);
    int reff, total, acc, t, t_last, k;
    bit fire, fire_prev, exp_done, ov;
    logic [A_W-1:0] na;
    logic [B_W-1:0] nb;
    logic [D_W-1:0] nd;

    reff  = (rows > DIM) ? DIM : rows;
    total = pre ? 2 * reff : reff;

    chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("idle_busy",      32'(o_busy), 0);
    chk("idle_op_ready",  32'(bus.op_ready), 0);

    bus.cmd_valid   = 1'b1;
    bus.cmd_rows    = 8'(rows);
    bus.cmd_shift   = SHIFT_W'(shift);
    bus.cmd_preload = pre;
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;

    m_prop    = m_prop ^ pre;
    m_shift   = SHIFT_W'(shift);
    acc       = 0;
    t_last    = 0;
    fire_prev = 1'b0;
    na = '0; nb = '0; nd = '0;

    for (t = 1; t <= 400; t++) begin
      if (fire_prev) begin
        m_a = na; m_b = nb; m_d = nd;
      end
      chk("valid",     32'(o_valid), 32'(fire_prev));
      chk("a",         32'(o_a), 32'(m_a));
      chk("b",         32'(o_b), 32'(m_b));
      chk("d",         32'(o_d), 32'(m_d));
      chk("shift",     32'(o_shift), 32'(m_shift));
      chk("prop",      32'(o_prop), 32'(m_prop));
      chk("op_ready",  32'(bus.op_ready), 32'(acc < total));
      exp_done = (total == 0) ? (t == 1) : (acc == total && t == t_last + DRAIN_CYCLES + 1);
      chk("done",      32'(o_done), 32'(exp_done));
      chk("busy",      32'(o_busy), 1);
      chk("cmd_ready", 32'(bus.cmd_ready), 0);

      if (exp_done) begin
        bus.op_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (t == abort_at) return;

      ov = rnd ? ($urandom_range(0, 3) != 0) : ((t - 1 < plen) ? pat[t - 1] : 1'b1);
      bus.op_valid = ov;
      if (fixed) begin
        k = acc - reff;
        bus.op_d = D_W'(7 + acc);
        bus.op_a = A_W'(1 + 2 * k);
        bus.op_b = B_W'(2 + 2 * k);
      end else begin
        bus.op_a = A_W'($urandom);
        bus.op_b = B_W'($urandom);
        bus.op_d = D_W'($urandom);
      end

      fire = ov && (acc < total);
      if (fire) begin
        if (pre && acc < reff) begin
          na = '0; nb = '0; nd = bus.op_d;
        end else begin
          na = bus.op_a; nb = bus.op_b; nd = '0;
        end
        acc++;
        if (acc == total) t_last = t;
      end
      fire_prev = fire;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $error("FAIL tile_timeout observed=no_done expected=done");
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_rows = '0; bus.cmd_shift = '0; bus.cmd_preload = 1'b0;
    bus.op_valid  = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_d = '0;
    model_reset();

    // Power-on reset
    #12;
    chk_all_zero("por");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("por_cmd_ready", 32'(bus.cmd_ready), 1);

    // Preload tile: rows=3, shift=5, d=7,8,9 then (1,2),(3,4),(5,6), no bubbles
    run_tile(3, 5, 1'b1, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 0);
    chk("preload_prop_lit",  32'(o_prop), 1);
    chk("preload_shift_lit", 32'(o_shift), 5);

    // Bubbles: rows=2, compute only, op_valid 1,0,0,1
    run_tile(2, 9, 1'b0, 1'b0, 1'b0, 1'b0, 4, 16'b1001, 0);
    chk("bubble_prop_lit", 32'(o_prop), 1);

    // Clamp: rows=40 yields DIM beats
    run_tile(40, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 0);

    // Zero rows with preload: straight to DONE, propagate toggles
    run_tile(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 0);
    chk("zero_prop_lit", 32'(o_prop), 0);

    // Back-to-back preload tiles with cmd_valid held across DONE
    run_tile(2, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 0);
    chk("b2b_prop1_lit", 32'(o_prop), 1);
    run_tile(2, 7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 0);
    chk("b2b_prop2_lit", 32'(o_prop), 0);

    // Reset mid-COMPUTE: 4 preload beats plus one compute beat, then reset
    run_tile(4, 12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 6);
    chk("pre_rst_valid", 32'(o_valid), 1);
    bus.op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy",      32'(o_busy), 0);
    chk("rst_prop",      32'(o_prop), 0);

    // Randomized tiles
    for (int i = 0; i < 30; i++) begin
      run_tile(int'($urandom_range(0, 20)), int'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               1'b1, 1'b0, 0, 16'h0000, 0);
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("end_idle_busy", 32'(o_busy), 1'b1 & bus.cmd_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
